branch_ctrl: RTL and testbench

- Branch/jump sub-sequencer of the multicycle control unit. The main FSM hands over after instruction decode via a start/done handshake.
- Drives the PC-update control bundle (PCWrite, PCWriteCond, EQorNE, GTorLT) consumed by pc_sel, plus the PCSource, ALU and link-register selects for beq, bne, ble, bgt, j, jal and jr.
- Moore machine: outputs depend only on the state register.

---
 rtl/branch_ctrl_pkg.sv | 40 ++++
 rtl/branch_ctrl_decode.sv | 21 ++
 rtl/branch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_branch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the branch/jump sub-sequencer and the main control unit.
package branch_ctrl_pkg;

  localparam int OP_W     = 6;
  localparam int LINK_REG = 31;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BR_ADDR  = 3'd1,
    BR_CMP   = 3'd2,
    JAL_LINK = 3'd3,
    J_WR     = 3'd4,
    JR_WR    = 3'd5,
    DONE     = 3'd6,
    ILLEGAL  = 3'd7
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_BLE   = 6'h06;
  localparam logic [OP_W-1:0] OP_BGT   = 6'h07;
  localparam logic [OP_W-1:0] FUNCT_JR = 6'h08;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUB_REG       = 2'd0;
  localparam logic [1:0] ALUB_FOUR      = 2'd1;
  localparam logic [1:0] ALUB_SEXT      = 2'd2;
  localparam logic [1:0] ALUB_SEXT_SHL2 = 2'd3;

  localparam logic [2:0] ALUOP_PASS_A = 3'd0;
  localparam logic [2:0] ALUOP_ADD    = 3'd1;
  localparam logic [2:0] ALUOP_SUB    = 3'd2;

endpackage

// File: rtl/branch_ctrl_decode.sv
// Maps an opcode/funct pair to the first state of its branch/jump sequence.
module branch_ctrl_decode
  import branch_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  input  logic [OP_W-1:0] funct_i,
  output state_e          next_o
);

  always_comb begin
    next_o = ILLEGAL;
    case (opcode_i)
      OP_BEQ, OP_BNE, OP_BLE, OP_BGT: next_o = BR_ADDR;
      OP_J:                           next_o = J_WR;
      OP_JAL:                         next_o = JAL_LINK;
      OP_RTYPE: if (funct_i == FUNCT_JR) next_o = JR_WR;
      default:                        next_o = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump sub-sequencer (Moore FSM) of the multicycle control unit.
// Optional branch statistics counters are enabled with BRANCH_CTRL_STATS_EN.
module branch_ctrl
  import branch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
`ifdef BRANCH_CTRL_STATS_EN
  input  logic            zero,
  input  logic            gt,
  input  logic            clr_stats,
  output logic [15:0]     br_count,
  output logic [15:0]     taken_count,
`endif
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            eq_or_ne,
  output logic            gt_or_lt,
  output logic [1:0]      pc_source,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_op,
  output logic            aluout_write,
  output logic            reg_write,
  output logic            reg_dst_link,
  output logic            mem_to_reg_pc
);

  state_e          state_q, state_d, decode_next;
  logic [OP_W-1:0] opcode_q, opcode_d;
  logic [OP_W-1:0] funct_q, funct_d;

  // funct is only needed at decode time; the latched copy is kept for the main FSM's view.
  logic unused_funct;
  assign unused_funct = ^funct_q;

  branch_ctrl_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .next_o   (decode_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = decode_next;
        opcode_d = opcode;
        funct_d  = funct;
      end
      BR_ADDR:  state_d = BR_CMP;
      BR_CMP:   state_d = DONE;
      JAL_LINK: state_d = J_WR;
      J_WR:     state_d = DONE;
      JR_WR:    state_d = DONE;
      DONE:     state_d = IDLE;
      ILLEGAL:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    done          = 1'b0;
    illegal       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    eq_or_ne      = 1'b0;
    gt_or_lt      = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REG;
    alu_op        = ALUOP_PASS_A;
    aluout_write  = 1'b0;
    reg_write     = 1'b0;
    reg_dst_link  = 1'b0;
    mem_to_reg_pc = 1'b0;
    case (state_q)
      BR_ADDR: begin
        alu_src_b    = ALUB_SEXT_SHL2;
        alu_op       = ALUOP_ADD;
        aluout_write = 1'b1;
      end
      // bne inverts the Zero test, ble inverts the Gt test; beq/bgt use them directly.
      BR_CMP: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        eq_or_ne      = (opcode_q == OP_BNE);
        gt_or_lt      = (opcode_q == OP_BLE);
      end
      JAL_LINK: begin
        reg_write     = 1'b1;
        reg_dst_link  = 1'b1;
        mem_to_reg_pc = 1'b1;
      end
      J_WR: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      JR_WR: begin
        alu_src_a = 1'b1;
        pc_write  = 1'b1;
      end
      DONE:    done = 1'b1;
      ILLEGAL: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BRANCH_CTRL_STATS_EN
  logic [15:0] br_count_q, br_count_d;
  logic [15:0] taken_count_q, taken_count_d;
  logic        taken;

  // Clear wins over counting; both counters stick at all-ones.
  always_comb begin
    taken = ((opcode_q == OP_BEQ) || (opcode_q == OP_BNE)) ? (eq_or_ne ? ~zero : zero)
                                                           : (gt_or_lt ? ~gt : gt);
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (clr_stats) begin
      br_count_d    = '0;
      taken_count_d = '0;
    end else if (state_q == BR_CMP) begin
      if (br_count_q != 16'hFFFF) br_count_d = br_count_q + 16'd1;
      if (taken && (taken_count_q != 16'hFFFF)) taken_count_d = taken_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: vector table plus scoreboard queue.
// Stats checks are compiled in when BRANCH_CTRL_STATS_EN is defined.
module tb_branch_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic       pc_write;
    logic       pc_write_cond;
    logic       eq_or_ne;
    logic       gt_or_lt;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       aluout_write;
    logic       reg_write;
    logic       reg_dst_link;
    logic       mem_to_reg_pc;
  } outs_t;

  typedef enum int {P_IDLE, P_BR_ADDR, P_BR_CMP, P_JAL_LINK, P_J_WR, P_JR_WR, P_DONE, P_ILLEGAL} phase_e;
  typedef enum int {K_BR, K_J, K_JAL, K_JR, K_ILL} kind_e;

  typedef struct {
    logic [5:0] opcode;
    logic [5:0] funct;
    kind_e      kind;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       busy, done, illegal, pc_write, pc_write_cond, eq_or_ne, gt_or_lt;
  logic [1:0] pc_source, alu_src_b;
  logic       alu_src_a, aluout_write, reg_write, reg_dst_link, mem_to_reg_pc;
  logic [2:0] alu_op;
`ifdef BRANCH_CTRL_STATS_EN
  logic        zero = 1'b0;
  logic        gt = 1'b0;
  logic        clr_stats = 1'b0;
  logic [15:0] brCount, takenCount;
`endif

  outs_t sbQ[$];
  int    total = 0;
  int    bad = 0;
  int    doneSeen = 0;
  logic  invOn = 1'b0;
  vec_t  vecs[12];

  branch_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .opcode        (opcode),
    .funct         (funct),
`ifdef BRANCH_CTRL_STATS_EN
    .zero          (zero),
    .gt            (gt),
    .clr_stats     (clr_stats),
    .br_count      (brCount),
    .taken_count   (takenCount),
`endif
    .busy          (busy),
    .done          (done),
    .illegal       (illegal),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .eq_or_ne      (eq_or_ne),
    .gt_or_lt      (gt_or_lt),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .aluout_write  (aluout_write),
    .reg_write     (reg_write),
    .reg_dst_link  (reg_dst_link),
    .mem_to_reg_pc (mem_to_reg_pc)
  );

  initial forever #5 clk = ~clk;

  function automatic outs_t sampleDut();
    outs_t o;
    o.busy = busy; o.done = done; o.illegal = illegal;
    o.pc_write = pc_write; o.pc_write_cond = pc_write_cond;
    o.eq_or_ne = eq_or_ne; o.gt_or_lt = gt_or_lt; o.pc_source = pc_source;
    o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b; o.alu_op = alu_op;
    o.aluout_write = aluout_write; o.reg_write = reg_write;
    o.reg_dst_link = reg_dst_link; o.mem_to_reg_pc = mem_to_reg_pc;
    return o;
  endfunction

  // Expected control bundle of each sequencer step, written from the behaviour table.
  function automatic outs_t phaseOut(phase_e p, logic [5:0] op);
    outs_t o = '0;
    o.busy = (p != P_IDLE);
    case (p)
      P_BR_ADDR:  begin o.alu_src_b = 2'd3; o.alu_op = 3'd1; o.aluout_write = 1'b1; end
      P_BR_CMP:   begin
        o.alu_src_a = 1'b1; o.alu_op = 3'd2; o.pc_source = 2'd1; o.pc_write_cond = 1'b1;
        o.eq_or_ne = (op == 6'h05); o.gt_or_lt = (op == 6'h06);
      end
      P_JAL_LINK: begin o.reg_write = 1'b1; o.reg_dst_link = 1'b1; o.mem_to_reg_pc = 1'b1; end
      P_J_WR:     begin o.pc_source = 2'd2; o.pc_write = 1'b1; end
      P_JR_WR:    begin o.alu_src_a = 1'b1; o.pc_write = 1'b1; end
      P_DONE:     o.done = 1'b1;
      P_ILLEGAL:  begin o.done = 1'b1; o.illegal = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic void pushSeq(kind_e k, logic [5:0] op);
    sbQ.push_back(phaseOut(P_IDLE, op));
    case (k)
      K_BR:  begin sbQ.push_back(phaseOut(P_BR_ADDR, op)); sbQ.push_back(phaseOut(P_BR_CMP, op)); end
      K_J:   sbQ.push_back(phaseOut(P_J_WR, op));
      K_JAL: begin sbQ.push_back(phaseOut(P_JAL_LINK, op)); sbQ.push_back(phaseOut(P_J_WR, op)); end
      K_JR:  sbQ.push_back(phaseOut(P_JR_WR, op));
      default: ;
    endcase
    sbQ.push_back(phaseOut(k == K_ILL ? P_ILLEGAL : P_DONE, op));
    sbQ.push_back(phaseOut(P_IDLE, op));
  endfunction

  task automatic checkOutput(string name);
    outs_t act, exp;
    act = sampleDut();
    total++;
    if (act.done) doneSeen++;
    if (sbQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s: got %h, scoreboard empty", name, act);
    end else begin
      exp = sbQ.pop_front();
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
    end
  endtask

  task automatic checkValue(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drives one start pulse, then scrambles opcode/funct so the DUT must rely on its latch.
  task automatic applyStimulus(logic [5:0] op, logic [5:0] fn, kind_e k, string name);
    int n;
    pushSeq(k, op);
    n = sbQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s c%0d", name, i));
      start  = (i == 0);
      opcode = (i == 0) ? op : 6'($urandom);
      funct  = (i == 0) ? fn : 6'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (invOn) begin
      total++;
      if (pc_write && pc_write_cond) begin
        bad++;
        $display("[TB] FAIL inv_pcwrite: pc_write=%b pc_write_cond=%b want not both", pc_write, pc_write_cond);
      end
      total++;
      if (reg_write && !(reg_dst_link && mem_to_reg_pc && !pc_write)) begin
        bad++;
        $display("[TB] FAIL inv_regwrite: reg_write outside link step (dst=%b m2r=%b pcw=%b)",
                 reg_dst_link, mem_to_reg_pc, pc_write);
      end
    end
  end

  initial begin
    vecs[0]  = '{6'h04, 6'h00, K_BR,  "beq"};
    vecs[1]  = '{6'h05, 6'h3F, K_BR,  "bne"};
    vecs[2]  = '{6'h06, 6'h00, K_BR,  "ble"};
    vecs[3]  = '{6'h07, 6'h08, K_BR,  "bgt"};
    vecs[4]  = '{6'h02, 6'h00, K_J,   "j"};
    vecs[5]  = '{6'h03, 6'h00, K_JAL, "jal"};
    vecs[6]  = '{6'h00, 6'h08, K_JR,  "jr"};
    vecs[7]  = '{6'h00, 6'h20, K_ILL, "rtype_add"};
    vecs[8]  = '{6'h00, 6'h09, K_ILL, "rtype_jalr"};
    vecs[9]  = '{6'h23, 6'h08, K_ILL, "lw"};
    vecs[10] = '{6'h01, 6'h00, K_ILL, "op01"};
    vecs[11] = '{6'h08, 6'h00, K_ILL, "op08"};

    #1 reset_n = 1'b0;
    @(negedge clk);
    sbQ.push_back(phaseOut(P_IDLE, 6'h00));
    checkOutput("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    invOn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 12; v++)
      applyStimulus(vecs[v].opcode, vecs[v].funct, vecs[v].kind, vecs[v].name);

    // Start during BR_CMP (as a jump) and during DONE must both be ignored.
    doneSeen = 0;
    pushSeq(K_BR, 6'h04);
    sbQ.push_back(phaseOut(P_IDLE, 6'h00));
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("busy_start c%0d", i));
      start  = (i == 0) || (i == 2) || (i == 3);
      opcode = (i == 0) ? 6'h04 : 6'h02;
      funct  = 6'h00;
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    checkValue("busy_start_done_count", 16'(doneSeen), 16'd1);

    // Asynchronous reset while in JAL_LINK aborts the sequence without a done pulse.
    doneSeen = 0;
    pushSeq(K_JAL, 6'h03);
    checkOutput("rst_mid c0");
    start = 1'b1; opcode = 6'h03;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    checkOutput("rst_mid c1");
    #2 reset_n = 1'b0;
    #1;
    sbQ.delete();
    checkValue("rst_mid_regwrite", 16'(reg_write), 16'd0);
    sbQ.push_back(phaseOut(P_IDLE, 6'h00));
    checkOutput("rst_mid_async");
    @(posedge clk); @(negedge clk);
    sbQ.push_back(phaseOut(P_IDLE, 6'h00));
    checkOutput("rst_mid_held");
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    sbQ.push_back(phaseOut(P_IDLE, 6'h00));
    checkOutput("rst_mid_released");
    checkValue("rst_mid_no_done", 16'(doneSeen), 16'd0);
    applyStimulus(6'h00, 6'h08, K_JR, "jr_after_rst");

`ifdef BRANCH_CTRL_STATS_EN
    clr_stats = 1'b1;
    @(posedge clk); @(negedge clk);
    clr_stats = 1'b0;
    checkValue("stats_clr_br", brCount, 16'd0);
    zero = 1'b0; applyStimulus(6'h05, 6'h00, K_BR, "st_bne0");
    zero = 1'b1; applyStimulus(6'h05, 6'h00, K_BR, "st_bne1");
    zero = 1'b0; applyStimulus(6'h05, 6'h00, K_BR, "st_bne2");
    checkValue("stats_br3", brCount, 16'd3);
    checkValue("stats_taken2", takenCount, 16'd2);

    force dut.br_count_q = 16'hFFFF;
    force dut.taken_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.br_count_q;
    release dut.taken_count_q;
    zero = 1'b1; applyStimulus(6'h04, 6'h00, K_BR, "st_sat");
    checkValue("stats_sat_br", brCount, 16'hFFFF);
    checkValue("stats_sat_taken", takenCount, 16'hFFFF);

    clr_stats = 1'b1;
    applyStimulus(6'h04, 6'h00, K_BR, "st_clr");
    clr_stats = 1'b0;
    checkValue("stats_clr_br_cmp", brCount, 16'd0);
    checkValue("stats_clr_taken_cmp", takenCount, 16'd0);

    gt = 1'b1;
    applyStimulus(6'h07, 6'h00, K_BR, "st_bgt");
    applyStimulus(6'h06, 6'h00, K_BR, "st_ble");
    gt = 1'b0;
    checkValue("stats_gt_br", brCount, 16'd2);
    checkValue("stats_gt_taken", takenCount, 16'd1);
`endif

    invOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
